hcsr04_ranger: RTL
==================

HCSR04_RANGER -- requirements
Module: hcsr04_ranger

Interface
REQ-001 Parameter CLK_HZ, 50_000_000, system clock frequency in Hz.
REQ-002 Parameter TRIG_CYCLES, 500, trigger pulse width in clocks (10 us).
REQ-003 Parameter CYCLES_PER_CM, 2900, echo clocks per cm (58 us).
REQ-004 Parameter MAX_CM, 400, echo length in cm at which measurement is abandoned as timeout.
REQ-005 Parameter PERIOD_CYCLES, 3_000_000, minimum trigger-to-trigger spacing (60 ms).
REQ-006 Parameter RISE_TIMEOUT_CYCLES, 1_500_000, maximum wait for echo rising edge (30 ms).
REQ-007 clk  input  1  system clock; one clock domain, all logic on its rising edge.
REQ-008 rst  input  1  synchronous, active-high reset.
REQ-009 en  input  1  level; 1 permits new measurement cycles.
REQ-010 echo  input  1  asynchronous sensor echo pin.
REQ-011 trig  output  1  sensor trigger pin.
REQ-012 distance  output  12  last result in cm; held between updates.
REQ-013 valid  output  1  one-cycle pulse when distance is updated.
REQ-014 timeout  output  1  level; 1 while the latest result is a timeout.

Function
REQ-015 Echo passes through a 2-flop synchronizer; echo_s is its output; all echo decisions use echo_s only.
REQ-016 States IDLE, TRIG, WAIT_RISE, MEASURE, HOLDOFF.
REQ-017 IDLE: trig=0; when en=1, go to TRIG next cycle and clear the period counter.
REQ-018 TRIG: trig=1 for exactly TRIG_CYCLES clocks, then WAIT_RISE.
REQ-019 WAIT_RISE: echo_s=1 goes to MEASURE; RISE_TIMEOUT_CYCLES clocks without echo_s=1 produce a timeout result and go to HOLDOFF.
REQ-020 MEASURE: a sub-counter counts clocks with echo_s=1; on reaching CYCLES_PER_CM it wraps to 0 and the cm counter increments; result is floor(cycles/CYCLES_PER_CM).
REQ-021 MEASURE, echo_s=0 sampled: on the next edge distance = cm counter, valid=1 for one cycle, timeout=0; go to HOLDOFF.
REQ-022 MEASURE, cm counter reaching MAX_CM: timeout result; go to HOLDOFF.
REQ-023 Timeout result: distance=12'd4095, valid=1 for one cycle, timeout=1.
REQ-024 HOLDOFF: stay until the period counter (started at TRIG entry) reaches PERIOD_CYCLES, and echo_s=0; then IDLE.
REQ-025 en=0 mid-cycle: the current measurement completes normally; no new TRIG is started.
REQ-026 Every measurement produces exactly one valid pulse.
REQ-027 Counters saturate; they never wrap.

Reset
REQ-028 rst=1: state=IDLE, trig=0, distance=0, valid=0, timeout=0, all counters and synchronizer flops 0; this applies in every state, including mid-TRIG with trig deasserted the next cycle.

Configuration
REQ-029 Macro US_MEDIAN_EN defined: distance = median of the last three results (timeout counts as 4095); history is 0 after reset; valid and timeout timing is unchanged; timeout reflects the raw latest result.
REQ-030 US_MEDIAN_EN undefined: distance = raw latest result; no history registers.

Structure
REQ-031 Package ultrasonic_pkg holds the state enum and the 4095 timeout-distance constant.
REQ-032 Sub-module sync2 implements the echo synchronizer.

Verification
REQ-033 Reset, then en=1: trig high exactly 500 cycles; echo high 58000 cycles -> distance=20, one valid pulse, timeout=0.
REQ-034 Echo high 2899 cycles -> distance=0; echo high 2900 cycles -> distance=1.
REQ-035 No echo after trigger -> after 1_500_000 cycles in WAIT_RISE, distance=4095, valid pulse, timeout=1.
REQ-036 Echo held high -> at cm=400, distance=4095 and timeout=1; the next trigger waits until echo is low and 3_000_000 cycles have elapsed.
REQ-037 rst asserted mid-MEASURE -> next cycle all outputs 0, state IDLE; no valid pulse for the aborted measurement.
REQ-038 US_MEDIAN_EN, raw results 30, 10, 50 -> distance 0, 10, 30 after each valid pulse.

Source files
------------

// File: rtl/ultrasonic_pkg.sv
// Shared types and constants for the HC-SR04 ultrasonic ranger.
package ultrasonic_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_TRIG      = 3'd1,
        ST_WAIT_RISE = 3'd2,
        ST_MEASURE   = 3'd3,
        ST_HOLDOFF   = 3'd4
    } state_e;

    localparam int          DIST_W       = 12;
    localparam logic [11:0] TIMEOUT_DIST = 12'd4095;

    // Median of three unsigned distances.
    function automatic logic [11:0] med3(input logic [11:0] a,
                                         input logic [11:0] b,
                                         input logic [11:0] c);
        logic [11:0] lo;
        logic [11:0] hi;
        logic [11:0] mid;
        lo  = (a < b) ? a : b;
        hi  = (a < b) ? b : a;
        mid = (hi < c) ? hi : c;
        return (lo > mid) ? lo : mid;
    endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for the asynchronous echo pin.
module sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic [1:0] ff_q;

    // Shift the asynchronous input through two flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            ff_q <= 2'b00;
        end else begin
            ff_q <= {ff_q[0], d_i};
        end
    end

    assign q_o = ff_q[1];

endmodule

// File: rtl/hcsr04_ranger.sv
// HC-SR04 ranger: trigger, echo timing, cm conversion and timeout handling.
// Optional median-of-three output filter enabled by defining US_MEDIAN_EN.
module hcsr04_ranger
    import ultrasonic_pkg::*;
#(
    parameter int CLK_HZ              = 50_000_000,
    parameter int TRIG_CYCLES         = 500,
    parameter int CYCLES_PER_CM       = 2900,
    parameter int MAX_CM              = 400,
    parameter int PERIOD_CYCLES       = 3_000_000,
    parameter int RISE_TIMEOUT_CYCLES = 1_500_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        echo,
    output logic        trig,
    output logic [11:0] distance,
    output logic        valid,
    output logic        timeout
);

    localparam int PH_MAX = (TRIG_CYCLES > RISE_TIMEOUT_CYCLES) ? TRIG_CYCLES : RISE_TIMEOUT_CYCLES;
    localparam int PH_W   = $clog2(PH_MAX + 1);
    localparam int PER_W  = $clog2(PERIOD_CYCLES + 1);
    localparam int SUB_W  = $clog2(CYCLES_PER_CM + 1);

    localparam logic [PH_W-1:0]  TRIG_LAST  = PH_W'(TRIG_CYCLES - 1);
    localparam logic [PH_W-1:0]  RISE_LAST  = PH_W'(RISE_TIMEOUT_CYCLES - 1);
    localparam logic [PER_W-1:0] PERIOD_END = PER_W'(PERIOD_CYCLES);
    localparam logic [SUB_W-1:0] SUB_LAST   = SUB_W'(CYCLES_PER_CM - 1);
    localparam logic [11:0]      CM_LAST    = 12'(MAX_CM - 1);

    // A nonsensical configuration keeps the ranger parked in IDLE.
    localparam bit CFG_OK = (CLK_HZ > 0) && (TRIG_CYCLES >= 1) && (CYCLES_PER_CM >= 2) &&
                            (MAX_CM >= 1) && (MAX_CM < 4095) && (RISE_TIMEOUT_CYCLES >= 1);

    logic             echo_s;
    state_e           state_q,  state_d;
    logic [PH_W-1:0]  phase_q,  phase_d;
    logic [PER_W-1:0] period_q, period_d;
    logic [SUB_W-1:0] sub_q,    sub_d;
    logic [11:0]      cm_q,     cm_d;
    logic             trig_q,   trig_d;
    logic [11:0]      dist_q,   dist_d;
    logic             valid_q,  valid_d;
    logic             to_q,     to_d;
    logic             res_load_s;
    logic [11:0]      res_dist_s;
    logic             res_to_s;
    logic [11:0]      dist_new_s;

    sync2 u_sync2 (
        .clk (clk),
        .rst (rst),
        .d_i (echo),
        .q_o (echo_s)
    );

    // Next-state logic, counters and result capture request.
    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        sub_d      = sub_q;
        cm_d       = cm_q;
        res_load_s = 1'b0;
        res_dist_s = 12'd0;
        res_to_s   = 1'b0;
        if ((state_q != ST_IDLE) && (period_q != PERIOD_END)) begin
            period_d = period_q + {{(PER_W-1){1'b0}}, 1'b1};
        end else begin
            period_d = period_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (en && CFG_OK) begin
                    state_d  = ST_TRIG;
                    period_d = '0;
                    phase_d  = '0;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_TRIG: begin
                if (phase_q == TRIG_LAST) begin
                    state_d = ST_WAIT_RISE;
                    phase_d = '0;
                end else begin
                    phase_d = phase_q + {{(PH_W-1){1'b0}}, 1'b1};
                end
            end
            ST_WAIT_RISE: begin
                // The cycle that sees the rising edge is the first high clock counted.
                if (echo_s) begin
                    state_d = ST_MEASURE;
                    sub_d   = {{(SUB_W-1){1'b0}}, 1'b1};
                    cm_d    = 12'd0;
                end else if (phase_q == RISE_LAST) begin
                    state_d    = ST_HOLDOFF;
                    res_load_s = 1'b1;
                    res_dist_s = TIMEOUT_DIST;
                    res_to_s   = 1'b1;
                end else begin
                    phase_d = phase_q + {{(PH_W-1){1'b0}}, 1'b1};
                end
            end
            ST_MEASURE: begin
                if (!echo_s) begin
                    state_d    = ST_HOLDOFF;
                    res_load_s = 1'b1;
                    res_dist_s = cm_q;
                    res_to_s   = 1'b0;
                end else if (sub_q == SUB_LAST) begin
                    sub_d = '0;
                    cm_d  = cm_q + 12'd1;
                    if (cm_q == CM_LAST) begin
                        state_d    = ST_HOLDOFF;
                        res_load_s = 1'b1;
                        res_dist_s = TIMEOUT_DIST;
                        res_to_s   = 1'b1;
                    end else begin
                        state_d = ST_MEASURE;
                    end
                end else begin
                    sub_d = sub_q + {{(SUB_W-1){1'b0}}, 1'b1};
                end
            end
            ST_HOLDOFF: begin
                if ((period_q == PERIOD_END) && !echo_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_HOLDOFF;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

`ifdef US_MEDIAN_EN
    logic [11:0] hist0_q, hist0_d;
    logic [11:0] hist1_q, hist1_d;

    // History of the two previous raw results feeding the median filter.
    always_comb begin
        dist_new_s = med3(res_dist_s, hist0_q, hist1_q);
        if (res_load_s) begin
            hist0_d = res_dist_s;
            hist1_d = hist0_q;
        end else begin
            hist0_d = hist0_q;
            hist1_d = hist1_q;
        end
    end

    // History registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            hist0_q <= 12'd0;
            hist1_q <= 12'd0;
        end else begin
            hist0_q <= hist0_d;
            hist1_q <= hist1_d;
        end
    end
`else
    // Unfiltered output path.
    always_comb begin
        dist_new_s = res_dist_s;
    end
`endif

    // Registered output next values.
    always_comb begin
        trig_d  = (state_d == ST_TRIG);
        valid_d = res_load_s;
        if (res_load_s) begin
            dist_d = dist_new_s;
            to_d   = res_to_s;
        end else begin
            dist_d = dist_q;
            to_d   = to_q;
        end
    end

    // State, counters and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            phase_q  <= '0;
            period_q <= '0;
            sub_q    <= '0;
            cm_q     <= 12'd0;
            trig_q   <= 1'b0;
            dist_q   <= 12'd0;
            valid_q  <= 1'b0;
            to_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            period_q <= period_d;
            sub_q    <= sub_d;
            cm_q     <= cm_d;
            trig_q   <= trig_d;
            dist_q   <= dist_d;
            valid_q  <= valid_d;
            to_q     <= to_d;
        end
    end

    assign trig     = trig_q;
    assign distance = dist_q;
    assign valid    = valid_q;
    assign timeout  = to_q;

endmodule
